// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - shared constants and state encodings for the serial RAM loader
package ram_loader_pkg;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;
    localparam int         RAM_DEPTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 UART receiver with mid-bit sampling and framing error strobe
module uart_rx_8n1
    import ram_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_n;
    logic          valid_n, frame_err_n;
    logic          rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk) begin
        if (clr) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CW'(1);
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        data_n      = data;
        valid_n     = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_sync) state_n = RX_START;
            end
            RX_START: begin
                // a start bit that is high again at mid-bit was only a glitch
                if (cnt == HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL) begin
                    cnt_n     = '0;
                    shift_n   = {rx_sync, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                // returning to idle at mid stop bit lets the next start edge be caught
                if (cnt == FULL) begin
                    state_n = RX_IDLE;
                    if (rx_sync) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - UART bootloader that validates a sync/checksum frame and fills a 16-byte RAM
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CYC  = 1048576
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rx,
    output logic       ram_we,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_data,
    output logic       cpu_hold,
    output logic       done,
    output logic       err
);

    localparam int            TW       = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]    IDX_LAST = 4'(RAM_DEPTH - 1);

    logic [7:0]    rx_data;
    logic          rx_valid, rx_ferr;

    loader_state_t state, state_n;
    logic [3:0]    idx, idx_n;
    logic [7:0]    sum, sum_n;
    logic [TW-1:0] tmo, tmo_n;
    logic          tmo_hit;
    logic          we_n, hold_n, done_n, err_n;
    logic [3:0]    addr_n;
    logic [7:0]    wdata_n;

    uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .clr       (clr),
        .rx        (rx),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_ferr)
    );

    assign tmo_hit = (tmo == TMO_LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_IDLE;
            idx      <= '0;
            sum      <= '0;
            tmo      <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            sum      <= sum_n;
            tmo      <= tmo_n;
            ram_we   <= we_n;
            ram_addr <= addr_n;
            ram_data <= wdata_n;
            cpu_hold <= hold_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        sum_n   = sum;
        tmo_n   = tmo + TW'(1);
        we_n    = 1'b0;
        addr_n  = ram_addr;
        wdata_n = ram_data;
        hold_n  = cpu_hold;
        done_n  = 1'b0;
        err_n   = err;
        case (state)
            ST_IDLE: begin
                tmo_n = '0;
                if (rx_valid && rx_data == LOADER_SYNC) begin
                    state_n = ST_LOAD;
                    idx_n   = '0;
                    sum_n   = '0;
                    err_n   = 1'b0;
                    hold_n  = 1'b1;
                end
            end
            ST_LOAD: begin
                // a sync value here is ordinary data; no resync inside a frame
                if (rx_valid) begin
                    tmo_n   = '0;
                    we_n    = 1'b1;
                    addr_n  = idx;
                    wdata_n = rx_data;
                    sum_n   = sum + rx_data;
                    idx_n   = idx + 4'd1;
                    if (idx == IDX_LAST) state_n = ST_CHECK;
                end else if (rx_ferr || tmo_hit) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    state_n = ST_IDLE;
                    if (rx_data == sum) begin
                        done_n = 1'b1;
                        hold_n = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (rx_ferr || tmo_hit) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - directed table-driven bench for ram_loader
module tb_ram_loader;

    localparam int CPB = 8;
    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       rx  = 1'b1;
    logic       ram_we, cpu_hold, done, err;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;

    ram_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYC(TMO)) dut (
        .clk      (clk),
        .clr      (clr),
        .rx       (rx),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] first;
        logic [7:0] cs;
        logic       exp_done;
        logic       exp_err;
        logic       exp_hold;
    } vec_t;

    int         passed = 0;
    int         total  = 0;
    int         cyc    = 0;
    int         done_cnt = 0;
    int         we_double = 0;
    int         last_wr_cyc = 0;
    logic       prev_we = 1'b0;
    logic [3:0] wr_addr[$];
    logic [7:0] wr_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we) begin
            wr_addr.push_back(ram_addr);
            wr_data.push_back(ram_data);
            last_wr_cyc = cyc;
        end
        if (ram_we && prev_we) we_double++;
        prev_we = ram_we;
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    // called aligned to a negedge; returns on a negedge so calls run back-to-back
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int mism;
        clear_log();
        send_byte(8'hA5, 1'b1);
        idle(4);
        check({tag, "_sync_err"}, err, 0);
        check({tag, "_sync_hold"}, cpu_hold, 1);
        for (int i = 0; i < 16; i++) send_byte(v.first + 8'(i), 1'b1);
        send_byte(v.cs, 1'b1);
        idle(10);
        check({tag, "_nwrites"}, wr_addr.size(), 16);
        mism = 0;
        for (int i = 0; i < wr_addr.size() && i < 16; i++)
            if (wr_addr[i] !== 4'(i) || wr_data[i] !== v.first + 8'(i)) mism++;
        check({tag, "_wr_match"}, mism, 0);
        check({tag, "_done"}, done_cnt, 32'(v.exp_done));
        check({tag, "_err"}, err, 32'(v.exp_err));
        check({tag, "_hold"}, cpu_hold, 32'(v.exp_hold));
    endtask

    vec_t vecs[5];

    initial begin
        int err_cyc;
        vecs[0] = '{first: 8'h01, cs: 8'h88, exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};
        vecs[1] = '{first: 8'h01, cs: 8'h89, exp_done: 1'b0, exp_err: 1'b1, exp_hold: 1'b1};
        vecs[2] = '{first: 8'h01, cs: 8'h88, exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};
        vecs[3] = '{first: 8'hF8, cs: 8'hF8, exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};
        vecs[4] = '{first: 8'hA0, cs: 8'h78, exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};

        idle(4);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data", ram_data, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        clr = 1'b0;
        idle(4);

        for (int i = 0; i < 5; i++) begin
            case (i)
                3: begin
                    // noise in IDLE: plain bytes, a framing error, a short glitch
                    clear_log();
                    send_byte(8'h00, 1'b1);
                    send_byte(8'hFF, 1'b1);
                    send_byte(8'h3C, 1'b0);
                    idle(4);
                    rx = 1'b0;
                    idle(2);
                    rx = 1'b1;
                    idle(30);
                    check("noise_writes", wr_addr.size(), 0);
                    check("noise_hold", cpu_hold, 0);
                    check("noise_err", err, 0);

                    // timeout after sync plus five data bytes
                    clear_log();
                    send_byte(8'hA5, 1'b1);
                    for (int k = 0; k < 5; k++) send_byte(8'h40 + 8'(k), 1'b1);
                    err_cyc = -1;
                    for (int k = 0; k < 2300 && err_cyc < 0; k++) begin
                        @(negedge clk);
                        if (err) err_cyc = cyc;
                    end
                    check("tmo_seen", err_cyc >= 0, 1);
                    check("tmo_delay", err_cyc - last_wr_cyc, TMO);
                    check("tmo_writes", wr_addr.size(), 5);
                    check("tmo_hold", cpu_hold, 1);
                end
                4: begin
                    // framing error on the eighth data byte
                    clear_log();
                    send_byte(8'hA5, 1'b1);
                    for (int k = 0; k < 7; k++) send_byte(8'h10 + 8'(k), 1'b1);
                    send_byte(8'h17, 1'b0);
                    idle(6);
                    check("ferr_writes", wr_addr.size(), 7);
                    check("ferr_err", err, 1);
                    check("ferr_hold", cpu_hold, 1);

                    // clr after the ninth data byte of a fresh load
                    send_byte(8'hA5, 1'b1);
                    for (int k = 0; k < 9; k++) send_byte(8'h20 + 8'(k), 1'b1);
                    idle(3);
                    clr = 1'b1;
                    @(negedge clk);
                    check("clr_we", ram_we, 0);
                    check("clr_addr", ram_addr, 0);
                    check("clr_data", ram_data, 0);
                    check("clr_hold", cpu_hold, 0);
                    check("clr_done", done, 0);
                    check("clr_err", err, 0);
                    clr = 1'b0;
                    idle(3);
                end
                default: ;
            endcase
            run_frame(vecs[i], $sformatf("vec%0d", i));
        end

        check("we_single_cycle", we_double, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
